// File: rtl/program_loader_if.sv
// program_loader_if: stream-in and memory-write bus of the boot loader.
//   Byte stream : in_valid, in_byte (from source), in_ready (from loader)
//   Memory bus  : mem_we, mem_addr, mem_data (from loader)
//   Status      : core_R, done, error, words_loaded (from loader)
// master = byte source / memory side, slave = program_loader.
interface program_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data;
  logic              core_R;
  logic              done;
  logic              error;
  logic [7:0]        words_loaded;

  modport master (
    output in_valid, in_byte,
    input  in_ready, mem_we, mem_addr, mem_data, core_R, done, error, words_loaded
  );

  modport slave (
    input  in_valid, in_byte,
    output in_ready, mem_we, mem_addr, mem_data, core_R, done, error, words_loaded
  );
endinterface

// File: rtl/program_loader.sv
// program_loader: boot-time loader that assembles a byte stream into
// big-endian 32-bit words, writes them to instruction ROM / data RAM and
// holds the core in reset until the whole image is written.
// Stream: header byte N (word count), then 4*N payload bytes, MSB first.
// Ports:
//   clk  - system clock
//   R    - synchronous active-high reset
//   bus  - program_loader_if.slave (byte stream in, memory write out, status)
// Optional: define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte
// after the payload (CHECK state); mismatch aborts to ERROR.
//
// state  | meaning
// IDLE   | waiting for header byte
// LOAD   | accepting payload bytes, writing each completed word
// CHECK  | waiting for checksum byte (LOADER_CHECKSUM_EN only)
// FINISH | one-cycle settle, carries the final write strobe
// DONE   | image loaded, core released
// ERROR  | load aborted, core held in reset
module program_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 64
) (
  input  logic              clk,
  input  logic              R,
  program_loader_if.slave   bus
);
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, FINISH, DONE, ERROR} state_t;

  localparam logic [8:0] MAX_N = 9'(MAX_WORDS);

  state_t            state, state_nxt;
  logic              in_ready;
  logic              accept;
  logic              word_complete;
  logic              last_byte;
  logic [7:0]        n_words;
  logic [7:0]        word_idx;
  logic [1:0]        byte_cnt;
  logic [31:0]       word_sr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data;
  logic [7:0]        words_loaded;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  // R gates in_ready so no byte is consumed during the reset cycle.
  assign in_ready      = !R && (state == IDLE || state == LOAD || state == CHECK);
  assign accept        = bus.in_valid && in_ready;
  assign word_complete = accept && (state == LOAD) && (byte_cnt == 2'd3);
  assign last_byte     = word_complete && (word_idx == n_words - 8'd1);

  always_ff @(posedge clk) begin
    if (R) state <= IDLE;
    else   state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) begin
        if ({1'b0, bus.in_byte} > MAX_N) state_nxt = ERROR;
        else if (bus.in_byte == 8'd0) begin
`ifdef LOADER_CHECKSUM_EN
          state_nxt = CHECK;
`else
          state_nxt = FINISH;
`endif
        end
        else state_nxt = LOAD;
      end
      LOAD: if (last_byte) begin
`ifdef LOADER_CHECKSUM_EN
        state_nxt = CHECK;
`else
        state_nxt = FINISH;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: if (accept) state_nxt = (bus.in_byte == csum) ? FINISH : ERROR;
`endif
      FINISH:  state_nxt = DONE;
      DONE:    state_nxt = DONE;
      ERROR:   state_nxt = ERROR;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (R) begin
      n_words      <= '0;
      word_idx     <= '0;
      byte_cnt     <= '0;
      word_sr      <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_data     <= '0;
      words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      if (accept && state == IDLE) begin
        n_words  <= bus.in_byte;
        word_idx <= '0;
        byte_cnt <= '0;
      end
      if (accept && state == LOAD) begin
        word_sr  <= {word_sr[23:0], bus.in_byte};
        byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
        csum     <= csum ^ bus.in_byte;
`endif
      end
      if (word_complete) begin
        mem_we   <= 1'b1;
        mem_addr <= ADDR_W'({word_idx, 2'b00});
        mem_data <= {word_sr[23:0], bus.in_byte};
        word_idx <= word_idx + 8'd1;
        if (words_loaded < n_words) words_loaded <= words_loaded + 8'd1;
      end
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.mem_we       = mem_we;
  assign bus.mem_addr     = mem_addr;
  assign bus.mem_data     = mem_data;
  assign bus.words_loaded = words_loaded;
  assign bus.core_R       = (state != DONE);
  assign bus.done         = (state == DONE);
  assign bus.error        = (state == ERROR);
endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;
  logic clk = 1'b0;
  logic R   = 1'b1;
  always #5 clk = ~clk;

  program_loader_if #(.ADDR_W(8)) bus();
  program_loader #(.ADDR_W(8), .MAX_WORDS(64)) dut (
    .clk (clk),
    .R   (R),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  always @(negedge clk)
    if (bus.mem_we) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_data);
    end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  task automatic check_status(input string tag, input logic rdy, input logic cr,
                              input logic dn, input logic er);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'(rdy));
    check({tag, "_core_R"},   32'(bus.core_R),   32'(cr));
    check({tag, "_done"},     32'(bus.done),     32'(dn));
    check({tag, "_error"},    32'(bus.error),    32'(er));
  endtask

  task automatic check_write(input string tag, input logic [7:0] addr,
                             input logic [31:0] data, input logic [7:0] wl);
    check({tag, "_we"},   32'(bus.mem_we),       32'd1);
    check({tag, "_addr"}, 32'(bus.mem_addr),     32'(addr));
    check({tag, "_data"}, bus.mem_data,          data);
    check({tag, "_wl"},   32'(bus.words_loaded), 32'(wl));
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [7:0] b);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      check("send_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    bus.in_valid = 1'b0;
    R = 1'b1;
    @(negedge clk);
    check_status(tag, 1'b0, 1'b1, 1'b0, 1'b0);
    check({tag, "_we"},   32'(bus.mem_we),       32'd0);
    check({tag, "_addr"}, 32'(bus.mem_addr),     32'd0);
    check({tag, "_data"}, bus.mem_data,          32'd0);
    check({tag, "_wl"},   32'(bus.words_loaded), 32'd0);
    R = 1'b0;
    #1;
    check({tag, "_ready_after"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic load_and_check(input string tag, input logic [7:0] n,
                                input logic [31:0] w0, input logic [31:0] w1,
                                input int gap);
    logic [31:0] w;
    logic [7:0]  b;
    logic [7:0]  cs;
    cs = 8'h00;
    send(n);
    if (n != 0) repeat (gap) @(negedge clk);
    for (int k = 0; k < int'(n); k++) begin
      w = (k == 0) ? w0 : w1;
      for (int i = 0; i < 4; i++) begin
        b  = w[31 - 8*i -: 8];
        cs = cs ^ b;
        send(b);
        if (i == 3) check_write($sformatf("%s_w%0d", tag, k), 8'(4*k), w, 8'(k+1));
        else        check($sformatf("%s_nowe%0d_%0d", tag, k, i), 32'(bus.mem_we), 32'd0);
        if (!(k == int'(n) - 1 && i == 3)) repeat (gap) @(negedge clk);
      end
    end
`ifdef LOADER_CHECKSUM_EN
    check_status({tag, "_check"}, 1'b1, 1'b1, 1'b0, 1'b0);
    send(cs);
`endif
    check_status({tag, "_finish"}, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check_status({tag, "_done"}, 1'b0, 1'b0, 1'b1, 1'b0);
    check({tag, "_wl_final"}, 32'(bus.words_loaded), 32'(n));
    check({tag, "_nwrites"},  32'(wr_addr.size()),   32'(n));
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;

    // Reset state
    @(negedge clk);
    do_reset("reset");

    // Two-word load, continuous valid, then with gaps
    load_and_check("burst", 8'h02, 32'hE3A01005, 32'hE2812001, 0);
    do_reset("rst1");
    load_and_check("gapped", 8'h02, 32'hE3A01005, 32'hE2812001, 1);
    if (wr_addr.size() == 2) begin
      check("gapped_a0", 32'(wr_addr[0]), 32'h00);
      check("gapped_a1", 32'(wr_addr[1]), 32'h04);
      check("gapped_d1", wr_data[1], 32'hE2812001);
    end else check("gapped_wr_count", 32'(wr_addr.size()), 32'd2);

    // Bytes offered in DONE are not consumed
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'h55;
    repeat (4) @(negedge clk);
    bus.in_valid = 1'b0;
    check_status("done_hold", 1'b0, 1'b0, 1'b1, 1'b0);
    check("done_hold_nwrites", 32'(wr_addr.size()), 32'd2);

    // Empty image
    do_reset("rst2");
    load_and_check("empty", 8'h00, 32'h0, 32'h0, 0);

    // Oversized header
    do_reset("rst3");
    send(8'h41);
    check_status("big", 1'b0, 1'b1, 1'b0, 1'b1);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_byte = 8'(8'h10 + i);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check_status("big_after", 1'b0, 1'b1, 1'b0, 1'b1);
    check("big_wl", 32'(bus.words_loaded), 32'd0);
    check("big_nwrites", 32'(wr_addr.size()), 32'd0);

    // Boundary header: MAX_WORDS itself is legal
    do_reset("rst4");
    send(8'h40);
    check_status("max_hdr", 1'b1, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of a load
    do_reset("rst5");
    send(8'h02);
    send(8'hE3); send(8'hA0); send(8'h10); send(8'h05); send(8'hE2);
    check("mid_wl", 32'(bus.words_loaded), 32'd1);
    do_reset("midrst");
    load_and_check("fresh", 8'h01, 32'hAABBCCDD, 32'h0, 0);
    if (wr_addr.size() == 1) check("fresh_a0", 32'(wr_addr[0]), 32'h00);

`ifdef LOADER_CHECKSUM_EN
    // Checksum match / mismatch (0x12^0x34^0x56^0x78 = 0x08)
    do_reset("rst6");
    send(8'h01);
    send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    check_write("cs_ok_w", 8'h00, 32'h12345678, 8'd1);
    check_status("cs_ok_check", 1'b1, 1'b1, 1'b0, 1'b0);
    send(8'h08);
    @(negedge clk);
    check_status("cs_ok_done", 1'b0, 1'b0, 1'b1, 1'b0);

    do_reset("rst7");
    send(8'h01);
    send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    send(8'h09);
    check_status("cs_bad", 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check_status("cs_bad_hold", 1'b0, 1'b1, 1'b0, 1'b1);
    check("cs_bad_nwrites", 32'(wr_addr.size()), 32'd1);
    if (wr_data.size() == 1) check("cs_bad_data", wr_data[0], 32'h12345678);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
